// File: rtl/seq_shift_add_mult_if.sv
// Handshake and operand/result bundle for the sequential shift-add multiplier.
// The master drives a request; the slave (the multiplier) returns the product and status.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 4
);
  logic               START;
  logic               SIGNED;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] P;
  logic               READY;
  logic               DONE;
  logic               CNTVCO;
  logic               CNTVCON;

  modport master (
    output START, SIGNED, A, B,
    input  P, READY, DONE, CNTVCO, CNTVCON
  );

  modport slave (
    input  START, SIGNED, A, B,
    output P, READY, DONE, CNTVCO, CNTVCON
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one partial-product step per clock, WIDTH
// steps per product, unsigned or two's-complement operands. The last product
// is held in P until the next operation completes.
module seq_shift_add_mult #(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 blif_clk_net,
  input  logic                 blif_reset_net,
  seq_shift_add_mult_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               done_q, done_d;

  // Datapath helpers for the current step.
  logic               last_step;
  logic [WIDTH:0]     mcand_ext;
  logic [WIDTH:0]     acc_top;
  logic [WIDTH:0]     step_sum;
  logic               fill_bit;
  logic [AW-1:0]      acc_step;

  // Next-state and datapath step: add/subtract the multiplicand into the top
  // half of acc, then shift the whole accumulator right by one.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    sgn_d    = sgn_q;
    p_d      = p_q;
    done_d   = 1'b0;

    last_step = (cnt_q == CNT_LAST);
    mcand_ext = sgn_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
    acc_top   = acc_q[AW-1:WIDTH];

    // The final step of a signed product weights B's sign bit negatively.
    if (mplr_q[0]) begin
      step_sum = (sgn_q && last_step) ? acc_top - mcand_ext : acc_top + mcand_ext;
    end else begin
      step_sum = acc_top;
    end

    // Signed: replicate the sign. Unsigned: the carry already sits in step_sum's
    // top bit and moves down into the product, so the guard refills with zero.
    fill_bit = sgn_q ? step_sum[WIDTH] : 1'b0;
    acc_step = AW'({fill_bit, step_sum, acc_q[WIDTH-1:0]} >> 1);

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          mcand_d = bus.A;
          mplr_d  = bus.B;
          sgn_d   = bus.SIGNED & SIGNED_EN;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_step;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (last_step) begin
          p_d     = acc_step[2*WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge blif_clk_net) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!blif_reset_net) begin
      // NOTE: operand registers are reset too; they are few flops and it keeps
      // every observable and internal value deterministic after reset.
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  // Status outputs decoded from state and step count.
  assign bus.P       = p_q;
  assign bus.READY   = (state_q == IDLE);
  assign bus.DONE    = done_q;
  assign bus.CNTVCO  = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign bus.CNTVCON = ~bus.CNTVCO;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Testbench for seq_shift_add_mult: a 4-bit signed-capable instance plus two
// 8-bit instances (signed mode enabled / disabled). Drivers push expected
// products into per-instance queues; monitors pop and compare on DONE.
module tb_seq_shift_add_mult;

  logic clk;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  q4[$];
  logic [15:0] q8s[$];
  logic [15:0] q8u[$];

  seq_shift_add_mult_if #(.WIDTH(4)) if4 ();
  seq_shift_add_mult_if #(.WIDTH(8)) if8s ();
  seq_shift_add_mult_if #(.WIDTH(8)) if8u ();

  seq_shift_add_mult #(.WIDTH(4), .SIGNED_EN(1'b1)) dut4 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .bus            (if4)
  );

  seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8s (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .bus            (if8s)
  );

  seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8u (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_n),
    .bus            (if8u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event occurred that should not have", name);
  endtask

  // Reference: integer product of the operands interpreted per mode, truncated to 2*w bits.
  function automatic logic [15:0] ref_mul(input int w, input bit s,
                                          input logic [7:0] a, input logic [7:0] b);
    longint mask, av, bv, p;
    mask = (longint'(1) << w) - 1;
    av = longint'(a) & mask;
    bv = longint'(b) & mask;
    if (s) begin
      if (av >= (longint'(1) << (w - 1))) av -= (longint'(1) << w);
      if (bv >= (longint'(1) << (w - 1))) bv -= (longint'(1) << w);
    end
    p = av * bv;
    return 16'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // Monitors: compare the product whenever an instance signals DONE.
  always @(negedge clk) begin
    if (if4.DONE === 1'b1) begin
      if (q4.size() == 0) fail_now("dut4_spurious_done");
      else check("dut4_P", 64'(if4.P), 64'(q4.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (if8s.DONE === 1'b1) begin
      if (q8s.size() == 0) fail_now("dut8s_spurious_done");
      else check("dut8s_P", 64'(if8s.P), 64'(q8s.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (if8u.DONE === 1'b1) begin
      if (q8u.size() == 0) fail_now("dut8u_spurious_done");
      else check("dut8u_P", 64'(if8u.P), 64'(q8u.pop_front()));
    end
  end

  task automatic wait_ready4();
    int n = 0;
    while (if4.READY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("dut4_ready_timeout");
  endtask

  task automatic wait_ready8();
    int n = 0;
    while ((if8s.READY !== 1'b1 || if8u.READY !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("dut8_ready_timeout");
  endtask

  // One 4-bit operation; returns at the negedge of the DONE cycle.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s);
    logic [15:0] e;
    wait_ready4();
    e = ref_mul(4, s, {4'h0, a}, {4'h0, b});
    if4.START = 1'b1; if4.A = a; if4.B = b; if4.SIGNED = s;
    q4.push_back(e[7:0]);
    @(negedge clk);
    if4.START = 1'b0; if4.A = 4'($urandom); if4.B = 4'($urandom); if4.SIGNED = 1'($urandom);
    for (int i = 1; i <= 4; i++) begin
      check("dut4_run_ready", 64'(if4.READY), 64'(0));
      check("dut4_cntvco", 64'(if4.CNTVCO), 64'(i == 4));
      check("dut4_cntvcon", 64'(if4.CNTVCON), 64'(i != 4));
      @(negedge clk);
    end
    check("dut4_done", 64'(if4.DONE), 64'(1));
    check("dut4_ready_after", 64'(if4.READY), 64'(1));
  endtask

  // One 8-bit operation driven identically into both 8-bit instances.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s);
    wait_ready8();
    if8s.START = 1'b1; if8s.A = a; if8s.B = b; if8s.SIGNED = s;
    if8u.START = 1'b1; if8u.A = a; if8u.B = b; if8u.SIGNED = s;
    q8s.push_back(ref_mul(8, s, a, b));
    q8u.push_back(ref_mul(8, 1'b0, a, b));
    @(negedge clk);
    if8s.START = 1'b0; if8s.A = 8'($urandom); if8s.B = 8'($urandom);
    if8u.START = 1'b0; if8u.A = 8'($urandom); if8u.B = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      check("dut8s_run_ready", 64'(if8s.READY), 64'(0));
      check("dut8u_cntvco", 64'(if8u.CNTVCO), 64'(i == 8));
      @(negedge clk);
    end
    check("dut8s_done", 64'(if8s.DONE), 64'(1));
    check("dut8u_done", 64'(if8u.DONE), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    if4.START = 1'b0;  if4.SIGNED = 1'b0;  if4.A = '0;  if4.B = '0;
    if8s.START = 1'b0; if8s.SIGNED = 1'b0; if8s.A = '0; if8s.B = '0;
    if8u.START = 1'b0; if8u.SIGNED = 1'b0; if8u.A = '0; if8u.B = '0;

    // Reset for two cycles, then check reset values.
    repeat (2) @(negedge clk);
    check("rst_P", 64'(if4.P), 64'(0));
    check("rst_READY", 64'(if4.READY), 64'(1));
    check("rst_DONE", 64'(if4.DONE), 64'(0));
    check("rst_CNTVCO", 64'(if4.CNTVCO), 64'(0));
    check("rst_CNTVCON", 64'(if4.CNTVCON), 64'(1));
    check("rst_P8", 64'(if8s.P), 64'(0));
    rst_n = 1'b1;

    // Idle with no START: outputs stay put.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_P", 64'(if4.P), 64'(0));
      check("idle_READY", 64'(if4.READY), 64'(1));
      check("idle_DONE", 64'(if4.DONE), 64'(0));
    end

    // Directed 4-bit cases, each followed by a single-pulse check on DONE.
    op4(4'd15, 4'd9 + 4'd6, 1'b0);  @(negedge clk); check("dut4_done_pulse", 64'(if4.DONE), 64'(0));
    op4(4'd0, 4'd9, 1'b0);          @(negedge clk); check("dut4_done_pulse", 64'(if4.DONE), 64'(0));
    op4(4'b1000, 4'b0111, 1'b1);    @(negedge clk);
    op4(4'b1000, 4'b1000, 1'b1);    @(negedge clk);
    op4(4'b1111, 4'b0001, 1'b1);    @(negedge clk);
    check("dut4_hold_P", 64'(if4.P), 64'(8'hFF));

    // Busy and back-to-back: START held through RUN; second op accepted on DONE.
    wait_ready4();
    if4.START = 1'b1; if4.A = 4'd3; if4.B = 4'd5; if4.SIGNED = 1'b0;
    q4.push_back(8'd15);
    @(negedge clk);
    if4.A = 4'd7; if4.B = 4'd7;
    q4.push_back(8'd49);
    for (int i = 1; i <= 4; i++) begin
      check("b2b_busy1", 64'(if4.READY), 64'(0));
      @(negedge clk);
    end
    check("b2b_done1", 64'(if4.DONE), 64'(1));
    check("b2b_ready1", 64'(if4.READY), 64'(1));
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("b2b_busy2", 64'(if4.READY), 64'(0));
      check("b2b_cntvco2", 64'(if4.CNTVCO), 64'(j == 4));
      if (j == 4) if4.START = 1'b0;
    end
    @(negedge clk);
    check("b2b_done2", 64'(if4.DONE), 64'(1));
    @(negedge clk);
    check("b2b_done2_pulse", 64'(if4.DONE), 64'(0));
    check("b2b_idle", 64'(if4.READY), 64'(1));

    // Reset in the second RUN cycle aborts the operation and clears P.
    wait_ready4();
    if4.START = 1'b1; if4.A = 4'd9; if4.B = 4'd9; if4.SIGNED = 1'b0;
    q4.push_back(8'd81);
    @(negedge clk);
    if4.START = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_P", 64'(if4.P), 64'(0));
    check("abort_READY", 64'(if4.READY), 64'(1));
    check("abort_DONE", 64'(if4.DONE), 64'(0));
    check("abort_CNTVCON", 64'(if4.CNTVCON), 64'(1));
    void'(q4.pop_back());
    rst_n = 1'b1;
    @(negedge clk);
    op4(4'd2, 4'd3, 1'b0);
    @(negedge clk);

    // Randomized 4-bit operations with random gaps (gap 0 is back-to-back).
    for (int n = 0; n < 40; n++) begin
      int gap;
      op4(4'($urandom), 4'($urandom), 1'($urandom));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        @(negedge clk);
        check("dut4_rand_done_pulse", 64'(if4.DONE), 64'(0));
        repeat (gap - 1) @(negedge clk);
      end
    end

    // Directed 8-bit corners, including signed mode disabled by parameter.
    op8(8'hFF, 8'hFF, 1'b0); @(negedge clk);
    op8(8'h80, 8'h80, 1'b1); @(negedge clk);
    op8(8'h80, 8'h7F, 1'b1); @(negedge clk);
    op8(8'h7F, 8'hFF, 1'b1); @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Drain and confirm every expected product was observed.
    repeat (12) @(negedge clk);
    check("q4_drained", 64'(q4.size()), 64'(0));
    check("q8s_drained", 64'(q8s.size()), 64'(0));
    check("q8u_drained", 64'(q8u.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
